// File: rtl/writeback_unit.sv
// Register-file write port: merges single-cycle ALU results with buffered LSU results, round-robin, one write per cycle.
// Optional operand forwarding from pending results is enabled with WRITEBACK_FORWARD_EN.
module writeback_unit #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [4:0]                 alu_rd_index,
    input  logic [XLEN-1:0]            alu_result,
    input  logic                       lsu_valid,
    output logic                       lsu_ready,
    input  logic [4:0]                 lsu_rd_index,
    input  logic [XLEN-1:0]            lsu_result,
`ifdef WRITEBACK_FORWARD_EN
    input  logic [4:0]                 fwd_rs1_index,
    input  logic [4:0]                 fwd_rs2_index,
    output logic                       fwd_rs1_hit,
    output logic                       fwd_rs2_hit,
    output logic [XLEN-1:0]            fwd_rs1_data,
    output logic [XLEN-1:0]            fwd_rs2_data,
`endif
    output logic                       rf_write_en,
    output logic [4:0]                 rf_rd_index,
    output logic [XLEN-1:0]            rf_rd,
    output logic [$clog2(DEPTH):0]     lsu_pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_t;

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // a source holding valid while ready is low must keep its payload stable.

    logic [4:0]      fifo_idx  [DEPTH];
    logic [XLEN-1:0] fifo_data [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    src_t            last_grant;

    logic fifo_nonempty;
    logic grant_alu;
    logic grant_lsu;
    logic push;

    assign fifo_nonempty = (count != '0);
    assign lsu_ready     = (count != CW'(DEPTH));
    assign alu_ready     = !(fifo_nonempty && last_grant == SRC_ALU);
    assign grant_alu     = alu_valid && alu_ready;
    assign grant_lsu     = fifo_nonempty && (!alu_valid || last_grant == SRC_ALU);
    // Writes to x0 are acknowledged but never occupy a FIFO slot.
    assign push          = lsu_valid && lsu_ready && (lsu_rd_index != 5'd0);
    assign lsu_pending   = count;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_idx[wr_ptr]  <= lsu_rd_index;
            fifo_data[wr_ptr] <= lsu_result;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            last_grant  <= SRC_LSU;
            rf_write_en <= 1'b0;
            rf_rd_index <= 5'd0;
            rf_rd       <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (grant_lsu) rd_ptr <= rd_ptr + 1'b1;
            case ({push, grant_lsu})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (grant_alu) last_grant <= SRC_ALU;
            else if (grant_lsu) last_grant <= SRC_LSU;

            // Index and data hold their last value when no write is issued.
            if (grant_alu && alu_rd_index != 5'd0) begin
                rf_write_en <= 1'b1;
                rf_rd_index <= alu_rd_index;
                rf_rd       <= alu_result;
            end else if (grant_lsu) begin
                rf_write_en <= 1'b1;
                rf_rd_index <= fifo_idx[rd_ptr];
                rf_rd       <= fifo_data[rd_ptr];
            end else begin
                rf_write_en <= 1'b0;
            end
        end
    end

`ifdef WRITEBACK_FORWARD_EN
    // Walk oldest to youngest so the youngest matching entry overrides older ones and the output register.
    always_comb begin
        logic [PW-1:0] slot;
        fwd_rs1_hit  = rf_write_en && (rf_rd_index == fwd_rs1_index);
        fwd_rs1_data = fwd_rs1_hit ? rf_rd : '0;
        fwd_rs2_hit  = rf_write_en && (rf_rd_index == fwd_rs2_index);
        fwd_rs2_data = fwd_rs2_hit ? rf_rd : '0;
        slot = rd_ptr;
        for (int i = 0; i < DEPTH; i++) begin
            slot = rd_ptr + PW'(i);
            if (CW'(i) < count && fifo_idx[slot] == fwd_rs1_index) begin
                fwd_rs1_hit  = 1'b1;
                fwd_rs1_data = fifo_data[slot];
            end
            if (CW'(i) < count && fifo_idx[slot] == fwd_rs2_index) begin
                fwd_rs2_hit  = 1'b1;
                fwd_rs2_data = fifo_data[slot];
            end
        end
        if (fwd_rs1_index == 5'd0) begin
            fwd_rs1_hit  = 1'b0;
            fwd_rs1_data = '0;
        end
        if (fwd_rs2_index == 5'd0) begin
            fwd_rs2_hit  = 1'b0;
            fwd_rs2_data = '0;
        end
    end
`endif

endmodule
